mac_feeder: RTL

- Initiator and sequencer for mac_unit: walks one dense layer neuron by neuron.
- Per neuron: reads activation and weight SRAMs (1-cycle read latency), drives the MAC operand/valid/clear inputs, and waits for the accumulator to settle.
- Then adds the neuron bias, applies optional ReLU and saturation to Q4.12, and emits one result per neuron over a valid/ready handshake.
- Sits between the layer memories and mac_unit; its output feeds the next-layer activation writer or the argmax stage.

---
 rtl/nn_pkg.sv | 48 ++++
 rtl/mac_feeder_if.sv | 57 +++++
 rtl/nn_postproc.sv | 38 +++
 rtl/mac_feeder.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// -----------------------------------------------------------------------------
// nn_pkg
// Shared definitions for the dense-layer datapath.
//   FRAC / DW / ACCW : Q4.12 operand format and MAC accumulator width
//   feeder_state_t   : sequencer states of mac_feeder
//   addr_w()         : address width for a memory of 'depth' words (min 1 bit)
//   sat_relu()       : optional ReLU followed by saturation of an accumulator
//                      value to a Q4.12 word; usable by any post-processing stage
// -----------------------------------------------------------------------------
package nn_pkg;

  localparam int FRAC = 12;
  localparam int DW   = 16;
  localparam int ACCW = 40;

  // Saturation limits of a DW-bit signed word, expressed at accumulator width.
  localparam logic signed [ACCW-1:0] Q_MAX = ACCW'((2 ** (DW - 1)) - 1);
  localparam logic signed [ACCW-1:0] Q_MIN = -Q_MAX - 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_RUN,
    ST_DRAIN,
    ST_POST,
    ST_OUT
  } feeder_state_t;

  // A single-word memory still needs a 1-bit address port.
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic logic signed [DW-1:0] sat_relu(
    input logic signed [ACCW-1:0] v,
    input logic                   relu_en
  );
    logic signed [ACCW-1:0] t;
    t = (relu_en && (v < 0)) ? '0 : v;
    if (t > Q_MAX) begin
      return Q_MAX[DW-1:0];
    end else if (t < Q_MIN) begin
      return Q_MIN[DW-1:0];
    end
    return t[DW-1:0];
  endfunction

endpackage

// File: rtl/mac_feeder_if.sv
// -----------------------------------------------------------------------------
// mac_feeder_if
// Bus bundle between the layer sequencer and its surroundings.
//   Memory reads : x_addr/x_rdata (activations), w_addr/w_rdata (weights,
//                  neuron-major), b_addr/b_rdata (biases); 1-cycle read latency
//   MAC drive    : mac_x, mac_w, mac_valid, mac_clr -> mac_unit; mac_acc back
//   Result       : res_valid/res_ready handshake with res_data (Q4.12), res_idx
// Modports: master = sequencer side, slave = memories / MAC / downstream side.
// -----------------------------------------------------------------------------
interface mac_feeder_if import nn_pkg::*; #(
  parameter int N_IN  = 784,
  parameter int N_OUT = 10,
  parameter int DW    = nn_pkg::DW,
  parameter int ACCW  = nn_pkg::ACCW
) ();

  localparam int XAW = addr_w(N_IN);
  localparam int WAW = addr_w(N_IN * N_OUT);
  localparam int BAW = addr_w(N_OUT);

  logic        [XAW-1:0]  x_addr;
  logic signed [DW-1:0]   x_rdata;
  logic        [WAW-1:0]  w_addr;
  logic signed [DW-1:0]   w_rdata;
  logic        [BAW-1:0]  b_addr;
  logic signed [DW-1:0]   b_rdata;

  logic signed [DW-1:0]   mac_x;
  logic signed [DW-1:0]   mac_w;
  logic                   mac_valid;
  logic                   mac_clr;
  logic signed [ACCW-1:0] mac_acc;

  logic                   res_valid;
  logic                   res_ready;
  logic signed [DW-1:0]   res_data;
  logic        [BAW-1:0]  res_idx;

  modport master (
    output x_addr, w_addr, b_addr,
    input  x_rdata, w_rdata, b_rdata,
    output mac_x, mac_w, mac_valid, mac_clr,
    input  mac_acc,
    output res_valid, res_data, res_idx,
    input  res_ready
  );

  modport slave (
    input  x_addr, w_addr, b_addr,
    output x_rdata, w_rdata, b_rdata,
    input  mac_x, mac_w, mac_valid, mac_clr,
    output mac_acc,
    input  res_valid, res_data, res_idx,
    output res_ready
  );

endinterface

// File: rtl/nn_postproc.sv
// -----------------------------------------------------------------------------
// nn_postproc
// Combinational neuron finish: bias add, optional ReLU, saturation to DW bits.
//   acc    in  ACCW  settled MAC accumulator (already Q.12 scaled)
//   bias   in  DW    Q4.12 bias, sign-extended before the add
//   result out DW    Q4.12 result, clamped to the signed DW-bit range
// The caller registers the result.
// -----------------------------------------------------------------------------
module nn_postproc #(
  parameter int DW      = 16,
  parameter int ACCW    = 40,
  parameter bit RELU_EN = 1'b1
) (
  input  logic signed [ACCW-1:0] acc,
  input  logic signed [DW-1:0]   bias,
  output logic signed [DW-1:0]   result
);

  localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'((2 ** (DW - 1)) - 1);
  localparam logic signed [ACCW-1:0] SAT_MIN = -SAT_MAX - 1;

  logic signed [ACCW-1:0] sum;

  always_comb begin
    sum = acc + ACCW'(bias);
    if (RELU_EN && (sum < 0)) begin
      sum = '0;
    end
    if (sum > SAT_MAX) begin
      result = SAT_MAX[DW-1:0];
    end else if (sum < SAT_MIN) begin
      result = SAT_MIN[DW-1:0];
    end else begin
      result = sum[DW-1:0];
    end
  end

endmodule

// File: rtl/mac_feeder.sv
// -----------------------------------------------------------------------------
// mac_feeder
// Sequencer for mac_unit: walks a dense layer neuron by neuron. For each neuron
// it clears the MAC, streams N_IN activation/weight pairs from the layer
// memories into it, waits for the accumulator to settle, adds the bias, applies
// ReLU/saturation and offers the result on a valid/ready handshake.
//   clk   in   clock
//   rst   in   synchronous active-high reset
//   start in   one-cycle pulse beginning a layer (ignored while busy)
//   busy  out  high from start acceptance until the final handshake
//   done  out  one-cycle pulse after the last neuron's result is accepted
//   bus   master modport of mac_feeder_if (memories, MAC, result channel)
// -----------------------------------------------------------------------------
module mac_feeder import nn_pkg::*; #(
  parameter int N_IN    = 784,
  parameter int N_OUT   = 10,
  parameter int DW      = nn_pkg::DW,
  parameter int ACCW    = nn_pkg::ACCW,
  parameter bit RELU_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         busy,
  output logic         done,
  mac_feeder_if.master bus
);

  localparam int XAW = addr_w(N_IN);
  localparam int WAW = addr_w(N_IN * N_OUT);
  localparam int BAW = addr_w(N_OUT);

  feeder_state_t state_reg, state_next;

  logic        [XAW-1:0] k_reg;
  logic        [WAW-1:0] w_cnt_reg;
  logic        [BAW-1:0] neuron_reg;
  logic                  drain_cnt_reg;
  logic                  mac_valid_reg;
  logic                  done_reg;
  logic                  res_valid_reg;
  logic signed [DW-1:0]  res_data_reg;
  logic        [BAW-1:0] res_idx_reg;

  logic                  issue;
  logic                  last_k;
  logic                  last_neuron;
  logic                  handshake;
  logic signed [DW-1:0]  post_result;

  assign last_k      = (k_reg == XAW'(N_IN - 1));
  assign last_neuron = (neuron_reg == BAW'(N_OUT - 1));
  assign handshake   = (state_reg == ST_OUT) && bus.res_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE:  if (start) state_next = ST_CLR;
      ST_CLR:   state_next = ST_RUN;
      ST_RUN:   if (last_k) state_next = ST_DRAIN;
      // Second DRAIN cycle: the last accumulate has landed in mac_acc.
      ST_DRAIN: if (drain_cnt_reg) state_next = ST_POST;
      ST_POST:  state_next = ST_OUT;
      ST_OUT:   if (bus.res_ready) state_next = last_neuron ? ST_IDLE : ST_CLR;
      default:  state_next = ST_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    busy        = (state_reg != ST_IDLE);
    issue       = (state_reg == ST_RUN);
    bus.mac_clr = (state_reg == ST_CLR);
  end

  // Counters and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      k_reg         <= '0;
      w_cnt_reg     <= '0;
      neuron_reg    <= '0;
      drain_cnt_reg <= 1'b0;
      mac_valid_reg <= 1'b0;
      done_reg      <= 1'b0;
      res_valid_reg <= 1'b0;
      res_data_reg  <= '0;
      res_idx_reg   <= '0;
    end else begin
      // Memory data arrives one cycle after the address, so the MAC strobe
      // is the issue strobe delayed by one cycle.
      mac_valid_reg <= issue;
      done_reg      <= handshake && last_neuron;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            neuron_reg <= '0;
            w_cnt_reg  <= '0;
            k_reg      <= '0;
          end
        end
        ST_CLR: begin
          k_reg <= '0;
        end
        ST_RUN: begin
          // Weights are neuron-major, so the weight address simply keeps
          // counting across neurons.
          w_cnt_reg <= w_cnt_reg + WAW'(1);
          if (!last_k) begin
            k_reg <= k_reg + XAW'(1);
          end
        end
        ST_DRAIN: begin
          drain_cnt_reg <= ~drain_cnt_reg;
        end
        ST_POST: begin
          res_data_reg  <= post_result;
          res_idx_reg   <= neuron_reg;
          res_valid_reg <= 1'b1;
        end
        ST_OUT: begin
          if (bus.res_ready) begin
            res_valid_reg <= 1'b0;
            if (!last_neuron) begin
              neuron_reg <= neuron_reg + BAW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  nn_postproc #(
    .DW      (DW),
    .ACCW    (ACCW),
    .RELU_EN (RELU_EN)
  ) u_postproc (
    .acc    (bus.mac_acc),
    .bias   (bus.b_rdata),
    .result (post_result)
  );

  assign bus.x_addr    = k_reg;
  assign bus.w_addr    = w_cnt_reg;
  assign bus.b_addr    = neuron_reg;
  assign bus.mac_valid = mac_valid_reg;
  // Operands are forced to zero outside accumulate cycles so the MAC inputs
  // are quiet whenever they are not being consumed.
  assign bus.mac_x     = mac_valid_reg ? bus.x_rdata : '0;
  assign bus.mac_w     = mac_valid_reg ? bus.w_rdata : '0;
  assign bus.res_valid = res_valid_reg;
  assign bus.res_data  = res_data_reg;
  assign bus.res_idx   = res_idx_reg;
  assign done          = done_reg;

endmodule
